rom_arbiter: RTL and testbench

- Shares the single-port, 1-cycle-latency instruction ROM between two requesters.
- Port 0 is the instruction-fetch stage; port 1 is the data/constant-load path.
- Issues at most one ROM read per cycle, using round-robin arbitration (or fixed priority by parameter).
- Routes each returned word to its originating port, tagged by a registered grant ID, and flags out-of-range addresses.

---
 rtl/rom_arbiter.sv | 99 +++++++++
 tb/tb_rom_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency instruction ROM.
// Round-robin or fixed priority; responses are routed back by a registered tag.
module rom_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ROM_DEPTH  = 1024,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  rom_rd_ena,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  // One extra bit so a ROM_DEPTH of 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(ROM_DEPTH);

  logic last_q, last_d;
  logic tag_vld_q, tag_vld_d;
  logic tag_id_q, tag_id_d;
  logic tag_oor_q, tag_oor_d;
  logic any_gnt;
  logic addr_oor;
  logic rsp0, rsp1;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        // last_q == 1 means port 1 won last time, so port 0 is owed the grant.
        if ((FIXED_PRIO != 0) || last_q) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = 1'b1;
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign any_gnt     = m0_gnt | m1_gnt;
  assign rom_address = m1_gnt ? m1_addr : m0_addr;
  assign addr_oor    = ({1'b0, rom_address} >= DEPTH_EXT);
  assign rom_rd_ena  = any_gnt & ~addr_oor;

  always_comb begin
    last_d    = last_q;
    tag_vld_d = any_gnt;
    tag_id_d  = m1_gnt;
    tag_oor_d = any_gnt & addr_oor;
    if (m1_gnt) begin
      last_d = 1'b1;
    end else if (m0_gnt) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q    <= 1'b1;
      tag_vld_q <= 1'b0;
      tag_id_q  <= 1'b0;
      tag_oor_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      tag_oor_q <= tag_oor_d;
    end
  end

  // Gating with rst_n drops an in-flight response as soon as reset is applied.
  assign rsp0 = rst_n & tag_vld_q & ~tag_id_q;
  assign rsp1 = rst_n & tag_vld_q & tag_id_q;

  assign m0_rvalid = rsp0;
  assign m1_rvalid = rsp1;
  assign m0_err    = rsp0 & tag_oor_q;
  assign m1_err    = rsp1 & tag_oor_q;
  assign m0_rdata  = (rsp0 && !tag_oor_q) ? rom_data : '0;
  assign m1_rdata  = (rsp1 && !tag_oor_q) ? rom_data : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: one round-robin and one fixed-priority
// instance share stimulus; each has its own ROM model and expected-response queue.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;

  logic        g0_rr, g1_rr, v0_rr, v1_rr, e0_rr, e1_rr, ena_rr;
  logic [31:0] d0_rr, d1_rr, ra_rr, rd_rr;
  logic        g0_fp, g1_fp, v0_fp, v1_fp, e0_fp, e1_fp, ena_fp;
  logic [31:0] d0_fp, d1_fp, ra_fp, rd_fp;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROM_DEPTH(1024), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(g0_rr), .m0_rvalid(v0_rr), .m0_rdata(d0_rr), .m0_err(e0_rr),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(g1_rr), .m1_rvalid(v1_rr), .m1_rdata(d1_rr), .m1_err(e1_rr),
    .rom_rd_ena(ena_rr), .rom_address(ra_rr), .rom_data(rd_rr)
  );

  rom_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROM_DEPTH(1024), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(g0_fp), .m0_rvalid(v0_fp), .m0_rdata(d0_fp), .m0_err(e0_fp),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(g1_fp), .m1_rvalid(v1_fp), .m1_rdata(d1_fp), .m1_err(e1_fp),
    .rom_rd_ena(ena_fp), .rom_address(ra_fp), .rom_data(rd_fp)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  always @(posedge clk) if (ena_rr) rd_rr <= rom_f(ra_rr);
  always @(posedge clk) if (ena_fp) rd_fp <= rom_f(ra_fp);

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // g: 0 = no grant, 1 = port 0, 2 = port 1
  task automatic check_grant(input string nm, input bit fp, input int g,
                             input logic gnt0, input logic gnt1, input logic ena,
                             input logic [31:0] ra, input logic [31:0] a0,
                             input logic [31:0] a1, input bit keep);
    logic [31:0] a;
    bit oor;
    exp_t e;
    a   = (g == 2) ? a1 : a0;
    oor = (a >= 32'd1024);
    cmp({nm, ".m0_gnt"}, {31'b0, gnt0}, {31'b0, g == 1});
    cmp({nm, ".m1_gnt"}, {31'b0, gnt1}, {31'b0, g == 2});
    cmp({nm, ".rom_rd_ena"}, {31'b0, ena}, {31'b0, (g != 0) && !oor});
    cmp({nm, ".rom_address"}, ra, a);
    if (keep && g != 0) begin
      e.due  = cyc + 1;
      e.port = (g == 2);
      e.data = oor ? 32'h0 : rom_f(a);
      e.err  = oor;
      if (fp) q_fp.push_back(e);
      else    q_rr.push_back(e);
    end
  endtask

  task automatic step(input bit rst, input bit r0, input logic [31:0] a0,
                      input bit r1, input logic [31:0] a1,
                      input int g_rr, input int g_fp, input bit keep);
    @(posedge clk);
    #1;
    rst_n = rst; m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1;
    @(negedge clk);
    check_grant("rr", 1'b0, g_rr, g0_rr, g1_rr, ena_rr, ra_rr, a0, a1, keep);
    check_grant("fp", 1'b1, g_fp, g0_fp, g1_fp, ena_fp, ra_fp, a0, a1, keep);
  endtask

  task automatic mon(input string nm, input bit have, input exp_t e,
                     input logic v0, input logic v1, input logic [31:0] d0,
                     input logic [31:0] d1, input logic er0, input logic er1);
    if (have) begin
      cmp({nm, ".m0_rvalid"}, {31'b0, v0}, {31'b0, !e.port});
      cmp({nm, ".m1_rvalid"}, {31'b0, v1}, {31'b0, e.port});
      cmp({nm, ".rdata"}, e.port ? d1 : d0, e.data);
      cmp({nm, ".err"}, {31'b0, e.port ? er1 : er0}, {31'b0, e.err});
      cmp({nm, ".idle_port_rdata"}, e.port ? d0 : d1, 32'h0);
    end else begin
      cmp({nm, ".m0_rvalid_idle"}, {31'b0, v0}, 32'h0);
      cmp({nm, ".m1_rvalid_idle"}, {31'b0, v1}, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit have;
    have = 1'b0;
    e = '{due: 0, port: 1'b0, data: 32'h0, err: 1'b0};
    if (q_rr.size() > 0 && q_rr[0].due == cyc) begin
      e = q_rr.pop_front();
      have = 1'b1;
    end
    mon("rr", have, e, v0_rr, v1_rr, d0_rr, d1_rr, e0_rr, e1_rr);
    have = 1'b0;
    if (q_fp.size() > 0 && q_fp[0].due == cyc) begin
      e = q_fp.pop_front();
      have = 1'b1;
    end
    mon("fp", have, e, v0_fp, v1_fp, d0_fp, d1_fp, e0_fp, e1_fp);
  end

  initial begin
    // reset holds grants off even with a request pending
    step(0, 1, 32'h0, 1, 32'h3, 0, 0, 1);
    step(0, 1, 32'h0, 0, 32'h3, 0, 0, 1);
    // single port, back-to-back
    step(1, 1, 32'h0, 0, 32'h0, 1, 1, 1);
    step(1, 1, 32'h1, 0, 32'h0, 1, 1, 1);
    step(1, 1, 32'h2, 0, 32'h0, 1, 1, 1);
    step(1, 0, 32'h2, 0, 32'h0, 0, 0, 1);
    // fresh reset, then continuous contention
    step(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
    step(1, 1, 32'h10, 1, 32'h20, 1, 1, 1);
    step(1, 1, 32'h10, 1, 32'h20, 2, 1, 1);
    step(1, 1, 32'h10, 1, 32'h20, 1, 1, 1);
    step(1, 1, 32'h10, 1, 32'h20, 2, 1, 1);
    // m0 drops: m1 granted immediately in both modes
    step(1, 0, 32'h10, 1, 32'h21, 2, 2, 1);
    // idle 10 cycles
    for (int i = 0; i < 10; i++) step(1, 0, 32'h7, 0, 32'h8, 0, 0, 1);
    // pointer survived idle: rr owes port 0
    step(1, 1, 32'h30, 1, 32'h31, 1, 1, 1);
    step(1, 1, 32'h32, 1, 32'h33, 2, 1, 1);
    // out-of-range and boundary addresses
    step(1, 0, 32'h0, 1, 32'h400, 2, 2, 1);
    step(1, 1, 32'h3FF, 0, 32'h0, 1, 1, 1);
    step(1, 1, 32'hFFFF_FFFF, 1, 32'h3FF, 2, 1, 1);
    step(1, 0, 32'h0, 0, 32'h0, 0, 0, 1);
    // reset mid-flight: the m0 response is dropped
    step(1, 1, 32'h5, 0, 32'h0, 1, 1, 0);
    step(0, 0, 32'h5, 0, 32'h0, 0, 0, 1);
    step(1, 0, 32'h5, 0, 32'h0, 0, 0, 1);
    step(1, 1, 32'h40, 1, 32'h41, 1, 1, 1);
    step(1, 1, 32'h40, 1, 32'h41, 2, 1, 1);
    step(1, 0, 32'h0, 0, 32'h0, 0, 0, 1);
    step(1, 0, 32'h0, 0, 32'h0, 0, 0, 1);
    @(negedge clk);
    cmp("rr.queue_drained", q_rr.size(), 32'd0);
    cmp("fp.queue_drained", q_fp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
